// File: rtl/sync_fifo_v3.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_v3
// Brief    : Single-clock FIFO, standard or first-word-fall-through output,
//            programmable thresholds, overflow/underflow pulses.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_v3 #(
  parameter int AW            = 4,
  parameter int DW            = 16,
  parameter     RAM_STYLE_VAL = "block",
  parameter int FWFT          = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen,
  input  logic [DW-1:0] din,
  input  logic          ren,
  input  logic [AW:0]   prog_full_thresh,
  input  logic [AW:0]   prog_empty_thresh,
  output logic          full,
  output logic          empty,
  output logic          prog_full,
  output logic          prog_empty,
  output logic [AW:0]   room_avail,
  output logic [AW:0]   data_avail,
  output logic          overflow,
  output logic          underflow,
  output logic          dout_valid,
  output logic [DW-1:0] dout
);

  localparam int            c_words   = 1 << AW;
  localparam logic [AW:0]   c_depth   = (AW+1)'(c_words);
  localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);

  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt, r_room, w_cnt_nxt;
  logic          r_full, r_empty, r_prog_full, r_prog_empty;
  logic          r_overflow, r_underflow, r_dout_valid;
  logic [DW-1:0] r_dout, w_ram_q;
  logic          w_wr_acc, w_rd_acc, w_ram_rd, w_dout_valid_nxt, w_empty_nxt;

  assign w_wr_acc = wen & ~r_full;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_cnt_nxt = r_cnt + c_cnt_one;
      2'b01:   w_cnt_nxt = r_cnt - c_cnt_one;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  generate
    if (RAM_STYLE_VAL == "block") begin : g_ram_block
      (* ram_style = "block" *) logic [DW-1:0] mem [c_words];
      always_ff @(posedge clk)
        if (w_wr_acc) mem[r_wptr] <= din;
      assign w_ram_q = mem[r_rptr];
    end else begin : g_ram_styled
      (* ram_style = RAM_STYLE_VAL *) logic [DW-1:0] mem [c_words];
      always_ff @(posedge clk)
        if (w_wr_acc) mem[r_wptr] <= din;
      assign w_ram_q = mem[r_rptr];
    end
  endgenerate

  generate
    if (FWFT != 0) begin : g_fwft
      logic        r_wr_last;
      logic [AW:0] w_ram_cnt;
      // A word written on the previous edge is not yet eligible for prefetch,
      // giving the two-edge write-to-head latency.
      assign w_rd_acc         = ren & r_dout_valid;
      assign w_ram_cnt        = r_cnt - {{AW{1'b0}}, r_dout_valid};
      assign w_ram_rd         = (~r_dout_valid | w_rd_acc) &
                                (w_ram_cnt > {{AW{1'b0}}, r_wr_last});
      assign w_dout_valid_nxt = w_ram_rd | (r_dout_valid & ~w_rd_acc);
      assign w_empty_nxt      = ~w_dout_valid_nxt;
      always_ff @(posedge clk or posedge rst)
        if (rst) r_wr_last <= 1'b0;
        else     r_wr_last <= w_wr_acc;
    end else begin : g_std
      assign w_rd_acc         = ren & ~r_empty;
      assign w_ram_rd         = w_rd_acc;
      assign w_dout_valid_nxt = w_rd_acc;
      assign w_empty_nxt      = (w_cnt_nxt == '0);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_cnt        <= '0;
      r_room       <= c_depth;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_prog_full  <= 1'b0;
      r_prog_empty <= 1'b1;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + c_ptr_one;
      if (w_ram_rd) begin
        r_rptr <= r_rptr + c_ptr_one;
        r_dout <= w_ram_q;
      end
      r_cnt        <= w_cnt_nxt;
      r_room       <= c_depth - w_cnt_nxt;
      r_full       <= (w_cnt_nxt == c_depth);
      r_empty      <= w_empty_nxt;
      r_prog_full  <= (w_cnt_nxt >= prog_full_thresh);
      r_prog_empty <= (w_cnt_nxt <= prog_empty_thresh);
      r_overflow   <= wen & r_full;
      r_underflow  <= ren & r_empty;
      r_dout_valid <= w_dout_valid_nxt;
    end
  end

  assign full       = r_full;
  assign empty      = r_empty;
  assign prog_full  = r_prog_full;
  assign prog_empty = r_prog_empty;
  assign room_avail = r_room;
  assign data_avail = r_cnt;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
  assign dout_valid = r_dout_valid;
  assign dout       = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_v3.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_v3
// Brief    : Drives a standard-mode and an FWFT-mode FIFO with shared stimulus
//            and compares both against queue-based reference models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_v3;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, wen, ren;
  logic [DW-1:0] din;
  logic [AW:0]   pft, pet;

  logic          s_full, s_empty, s_pf, s_pe, s_ovf, s_unf, s_dv;
  logic [AW:0]   s_room, s_avail;
  logic [DW-1:0] s_dout;
  logic          f_full, f_empty, f_pf, f_pe, f_ovf, f_unf, f_dv;
  logic [AW:0]   f_room, f_avail;
  logic [DW-1:0] f_dout;

  sync_fifo_v3 #(.AW(AW), .DW(DW), .RAM_STYLE_VAL("block"), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wen(wen), .din(din), .ren(ren),
    .prog_full_thresh(pft), .prog_empty_thresh(pet),
    .full(s_full), .empty(s_empty), .prog_full(s_pf), .prog_empty(s_pe),
    .room_avail(s_room), .data_avail(s_avail), .overflow(s_ovf),
    .underflow(s_unf), .dout_valid(s_dv), .dout(s_dout));

  sync_fifo_v3 #(.AW(AW), .DW(DW), .RAM_STYLE_VAL("distributed"), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wen(wen), .din(din), .ren(ren),
    .prog_full_thresh(pft), .prog_empty_thresh(pet),
    .full(f_full), .empty(f_empty), .prog_full(f_pf), .prog_empty(f_pe),
    .room_avail(f_room), .data_avail(f_avail), .overflow(f_ovf),
    .underflow(f_unf), .dout_valid(f_dv), .dout(f_dout));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference models: plain queues; the FWFT model stamps each word with its
  // write edge so the head becomes visible two edges after it was written.
  typedef struct { logic [DW-1:0] d; int e; } ent_t;
  logic [DW-1:0] q0[$];
  ent_t          q1[$];
  logic [DW-1:0] m0_dout, m1_dout;
  logic          m0_dv, m0_ovf, m0_unf, m0_pf, m0_pe;
  logic          m1_pres, m1_ovf, m1_unf, m1_pf, m1_pe;
  int            edge_n = 0;

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m0_dout = '0; m0_dv = 1'b0; m0_ovf = 1'b0; m0_unf = 1'b0; m0_pf = 1'b0; m0_pe = 1'b1;
    m1_dout = '0; m1_pres = 1'b0; m1_ovf = 1'b0; m1_unf = 1'b0; m1_pf = 1'b0; m1_pe = 1'b1;
  endtask

  task automatic model_update();
    bit full_b, emp_b, pres_b;
    if (rst) begin
      model_reset();
      return;
    end
    edge_n++;
    full_b = (q0.size() == DEPTH);
    emp_b  = (q0.size() == 0);
    m0_ovf = wen && full_b;
    m0_unf = ren && emp_b;
    m0_dv  = 1'b0;
    if (ren && !emp_b) begin
      m0_dout = q0.pop_front();
      m0_dv   = 1'b1;
    end
    if (wen && !full_b) q0.push_back(din);
    m0_pf = (int'(q0.size()) >= int'(pft));
    m0_pe = (int'(q0.size()) <= int'(pet));

    full_b = (q1.size() == DEPTH);
    pres_b = m1_pres;
    m1_ovf = wen && full_b;
    m1_unf = ren && !pres_b;
    if (ren && pres_b) begin
      q1.delete(0);
      m1_pres = 1'b0;
    end
    if (wen && !full_b) q1.push_back('{din, edge_n});
    if (!m1_pres && q1.size() > 0 && q1[0].e <= edge_n - 2) begin
      m1_pres = 1'b1;
      m1_dout = q1[0].d;
    end
    m1_pf = (int'(q1.size()) >= int'(pft));
    m1_pe = (int'(q1.size()) <= int'(pet));
  endtask

  task automatic compare_all();
    check("std_full",  s_full,  q0.size() == DEPTH);
    check("std_empty", s_empty, q0.size() == 0);
    check("std_avail", s_avail, q0.size());
    check("std_room",  s_room,  DEPTH - q0.size());
    check("std_pf",    s_pf,    m0_pf);
    check("std_pe",    s_pe,    m0_pe);
    check("std_ovf",   s_ovf,   m0_ovf);
    check("std_unf",   s_unf,   m0_unf);
    check("std_dv",    s_dv,    m0_dv);
    check("std_dout",  s_dout,  m0_dout);
    check("fw_full",   f_full,  q1.size() == DEPTH);
    check("fw_empty",  f_empty, !m1_pres);
    check("fw_avail",  f_avail, q1.size());
    check("fw_room",   f_room,  DEPTH - q1.size());
    check("fw_pf",     f_pf,    m1_pf);
    check("fw_pe",     f_pe,    m1_pe);
    check("fw_ovf",    f_ovf,   m1_ovf);
    check("fw_unf",    f_unf,   m1_unf);
    check("fw_dv",     f_dv,    m1_pres);
    check("fw_dout",   f_dout,  m1_dout);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
    wen = w;
    din = d;
    ren = r;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; wen = 1'b0; ren = 1'b0; din = '0;
    pft = 5'd12; pet = 5'd3;
    model_reset();
    #1 rst = 1'b1;
    #1 compare_all();
    step();
    step();
    rst = 1'b0;

    // Fill to full, overflow attempt, drain past empty
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, DW'(i), 1'b0);
    idle(3);
    cyc(1'b1, 8'hEE, 1'b0);
    idle(1);
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, '0, 1'b1);
    idle(3);

    // Single word latency and consume
    cyc(1'b1, 8'hA5, 1'b0);
    idle(3);
    cyc(1'b0, '0, 1'b1);
    idle(2);

    // Steady state at eight words with simultaneous traffic
    for (int i = 0; i < 8; i++) cyc(1'b1, DW'($urandom), 1'b0);
    idle(3);
    for (int i = 0; i < 40; i++) cyc(1'b1, DW'($urandom), 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b0, '0, 1'b1);
    idle(3);

    // Underflow with concurrent write, then overflow with concurrent read
    cyc(1'b1, 8'h3C, 1'b1);
    idle(3);
    cyc(1'b0, '0, 1'b1);
    idle(2);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'($urandom), 1'b0);
    idle(3);
    cyc(1'b1, 8'h77, 1'b1);
    idle(2);

    // Random traffic with changing thresholds, including 0 and DEPTH
    for (int i = 0; i < 400; i++) begin
      int bw;
      if (i % 50 == 0) begin
        pft = (AW+1)'($urandom_range(0, DEPTH));
        pet = (AW+1)'($urandom_range(0, DEPTH));
      end
      bw = ((i / 100) % 2 == 0) ? 70 : 30;
      cyc($urandom_range(0, 99) < bw, DW'($urandom), $urandom_range(0, 99) < (100 - bw));
    end

    // Asynchronous reset mid-burst at nine words
    pft = 5'd12; pet = 5'd3;
    for (int i = 0; i < 2 * DEPTH; i++) cyc(1'b0, '0, 1'b1);
    idle(3);
    for (int i = 0; i < 9; i++) cyc(1'b1, DW'($urandom), 1'b0);
    wen = 1'b1;
    din = 8'h99;
    #3 rst = 1'b1;
    #1 begin
      model_reset();
      compare_all();
    end
    step();
    step();
    rst = 1'b0;
    cyc(1'b1, 8'h55, 1'b0);
    idle(3);
    cyc(1'b0, '0, 1'b1);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo_v3.md
Name: sync_fifo_v3

Overview:
Single-clock FIFO with parametrised width, depth and read mode. Selectable standard (read-request) or first-word-fall-through (FWFT) output, programmable almost-full/almost-empty thresholds, and overflow/underflow error pulses. Control and a simple-dual-port inferred RAM live inside the block. Drop-in successor to the existing sync FIFO for stream buffering between datapath stages.

Parameters:
AW, 4, address width; memory depth DEPTH = 2^AW words
DW, 16, data width
RAM_STYLE_VAL, "block", RAM inference attribute applied to the storage array
FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
wen  in  1  write request
din  in  DW  write data
ren  in  1  read request (standard) / head acknowledge (FWFT)
prog_full_thresh  in  AW+1  prog_full asserts when data_avail >= this value
prog_empty_thresh  in  AW+1  prog_empty asserts when data_avail <= this value
full  out  1  no write accepted
empty  out  1  no read accepted
prog_full  out  1  programmable almost-full
prog_empty  out  1  programmable almost-empty
room_avail  out  AW+1  free words, DEPTH - data_avail
data_avail  out  AW+1  stored words (FWFT: includes word held on dout)
overflow  out  1  one-cycle pulse, write rejected
underflow  out  1  one-cycle pulse, read rejected
dout_valid  out  1  dout carries valid data
dout  out  DW  read data

Behaviour:
- Reset (async assert, sync release): empty=1, full=0, prog_empty=1, prog_full=0, data_avail=0, room_avail=DEPTH, dout_valid=0, dout=0, overflow=0, underflow=0, pointers=0. RAM contents not reset.
- Accepted write: wen && !full at an edge. Writes to RAM[wptr], wptr+1 mod DEPTH. wen while full: write dropped, overflow=1 next cycle, even if ren is active in the same cycle.
- Standard mode accepted read: ren && !empty. RAM[rptr] appears on dout with dout_valid=1 exactly one cycle later. rptr+1 mod DEPTH. dout_valid otherwise 0; dout holds last read value. ren while empty: underflow=1 next cycle, even if wen is active in the same cycle.
- FWFT mode: internal prefetch moves head word from RAM to output register whenever output register is empty or being acknowledged. dout_valid=1 means dout is the head. empty = !dout_valid. ren && dout_valid consumes head; next word, if any, presented the following cycle. Acknowledged reads at back-to-back rate are allowed with no bubble when RAM is non-empty.
- FWFT latency: write into empty FIFO at edge k gives dout_valid=1 after edge k+2. Standard mode: empty deasserts after edge k; ren at k+1 gives dout at k+2.
- Counting: data_avail += accepted write, -= accepted read (FWFT: consumed head). Simultaneous accepted read and write leaves the count unchanged. full = (data_avail == DEPTH), empty per mode. All flags and counts are registered and update on the edge of the accepting event.
- FWFT capacity is DEPTH total including the output register; the prefetch never lets the RAM overrun.
- Pointers are AW bits and wrap naturally. Counts are AW+1 bits; DEPTH is representable.
- prog_full / prog_empty are computed from the next-state count, so they are coincident with data_avail. Threshold changes take effect on the next edge. Thresholds of 0 or DEPTH are legal: prog_full_thresh=0 gives prog_full always 1 after the first post-reset cycle.
- Reset mid-operation discards all contents and flags immediately.

Test Plan:
- AW=4, DW=8, FWFT=0: write 0x01..0x10 (16 words) -> full=1, data_avail=16, room_avail=0. 17th wen -> overflow pulse, data unchanged. 16 reads -> dout 0x01..0x10, each 1 cycle after ren, then empty=1.
- FWFT=1: single write 0xA5 at edge k -> dout_valid=1 and dout=0xA5 after edge k+2, data_avail=1. ren -> dout_valid=0 next cycle, empty=1.
- Simultaneous wen+ren with data_avail=8, continuous for 40 cycles -> data_avail stays 8, pointers wrap, output order preserved. Repeat in both modes.
- Both modes: ren on empty FIFO with wen=1 same cycle -> underflow pulse, write accepted, data_avail=1. wen on full with ren=1 -> overflow pulse, read accepted, data_avail=15.
- prog_full_thresh=12, prog_empty_thresh=3: fill 0->16 -> prog_empty drops when data_avail=4, prog_full rises when data_avail=12. Drain -> symmetric transitions.
- Assert rst asynchronously at data_avail=9 mid-burst -> all outputs return to reset values without a clock edge. After release, write 0x55 then read -> 0x55, with no stale data.
